// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode constants, controller state encoding, default
//                latencies and small helpers for the ALU issue controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Operation field and register index widths
    localparam int OPER_W = 7;
    localparam int REG_W  = 5;
    localparam int CNT_W  = 5;

    // Opcodes understood by the ALU; every other code is illegal
    localparam logic [OPER_W-1:0] OP_ADD = 7'h01;
    localparam logic [OPER_W-1:0] OP_SUB = 7'h02;
    localparam logic [OPER_W-1:0] OP_MUL = 7'h03;
    localparam logic [OPER_W-1:0] OP_DIV = 7'h04;

    // Default multi-cycle latencies
    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_DIV_LAT = 16;

    // Controller occupancy states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    // True for the four opcodes the ALU implements
    function automatic logic is_legal_op(input logic [OPER_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // A source register hits a forwarding source when both name the same
    // non-zero register; register 0 is hard-wired and never forwards.
    function automatic logic fwd_hit(input logic             src_vld,
                                     input logic [REG_W-1:0] src_rd,
                                     input logic [REG_W-1:0] rs);
        return src_vld && (src_rd != '0) && (rs == src_rd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_lat_lut.sv
`default_nettype none
// ============================================================================
//  Module      : alu_lat_lut
//  Description : Combinational opcode -> latency / illegal-flag lookup.
//                Single-cycle ops and illegal codes report a latency of 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_lat_lut
    import alu_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic [OPER_W-1:0] oper,
    output logic [CNT_W-1:0]  lat,
    output logic              illegal
);

    localparam logic [CNT_W-1:0] c_LAT_ONE = 5'd1;
    localparam logic [CNT_W-1:0] c_LAT_MUL = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] c_LAT_DIV = CNT_W'(DIV_LAT);

    // Decode the opcode into its execution latency and legality
    always_comb begin
        lat     = c_LAT_ONE;
        illegal = 1'b0;
        case (oper)
            OP_ADD:  lat = c_LAT_ONE;
            OP_SUB:  lat = c_LAT_ONE;
            OP_MUL:  lat = c_LAT_MUL;
            OP_DIV:  lat = c_LAT_DIV;
            default: begin
                lat     = c_LAT_ONE;
                illegal = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Single-issue ALU controller. Accepts one instruction at a
//                time, times its execution latency with a down-counter,
//                pulses out_valid on completion and selects operand
//                forwarding from the completing / last completed result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,   // 2..15
    parameter int DIV_LAT = DEF_DIV_LAT    // 2..31
) (
    input  logic              clk,
    input  logic              rst,
    // instruction offer
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPER_W-1:0] in_oper,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    // ALU control
    output logic [OPER_W-1:0] alu_oper,
    output logic              alu_fwd1,
    output logic              alu_fwd2,
    output logic              alu_cap,
    // completion
    output logic              out_valid,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_illegal,
    output logic              busy
);

    localparam logic [0:0] c_ST_IDLE = ST_IDLE;
    localparam logic [0:0] c_ST_EXEC = ST_EXEC;

    // Registered state
    logic [0:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [OPER_W-1:0] r_alu_oper;
    logic              r_fwd1;
    logic              r_fwd2;
    logic [REG_W-1:0]  r_rd;
    logic              r_illegal;
    logic [REG_W-1:0]  r_last_rd;
    logic              r_last_vld;

    // Combinational helpers
    logic [CNT_W-1:0]  w_lat;
    logic              w_lut_illegal;
    logic              w_done;
    logic              w_ready;
    logic              w_issue;
    logic              w_src_vld;
    logic [REG_W-1:0]  w_src_rd;
    logic              w_fwd1;
    logic              w_fwd2;

    alu_lat_lut #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_lat_lut (
        .oper    (in_oper),
        .lat     (w_lat),
        .illegal (w_lut_illegal)
    );

    // Completion, handshake and forwarding-source selection
    always_comb begin
        w_done  = (r_state == c_ST_EXEC) && (r_cnt == '0);
        w_ready = (r_state == c_ST_IDLE) || w_done;
        w_issue = in_valid && w_ready;
        // An instruction completing this cycle is the freshest result, but an
        // illegal one produces no result, so it falls back to the last legal one.
        if (w_done && !r_illegal) begin
            w_src_vld = 1'b1;
            w_src_rd  = r_rd;
        end else begin
            w_src_vld = r_last_vld;
            w_src_rd  = r_last_rd;
        end
        w_fwd1 = fwd_hit(w_src_vld, w_src_rd, in_rs1);
        w_fwd2 = fwd_hit(w_src_vld, w_src_rd, in_rs2);
    end

    // Occupancy FSM with latency down-counter and issue-time ALU controls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_alu_oper <= '0;
            r_fwd1     <= 1'b0;
            r_fwd2     <= 1'b0;
            r_rd       <= '0;
            r_illegal  <= 1'b0;
        end else if (w_issue) begin
            r_state    <= c_ST_EXEC;
            r_cnt      <= w_lat - 5'd1;
            r_alu_oper <= w_lut_illegal ? '0 : in_oper;
            r_fwd1     <= w_fwd1;
            r_fwd2     <= w_fwd2;
            r_rd       <= in_rd;
            r_illegal  <= w_lut_illegal;
        end else if (w_done) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_alu_oper <= '0;
            r_fwd1     <= 1'b0;
            r_fwd2     <= 1'b0;
            r_rd       <= '0;
            r_illegal  <= 1'b0;
        end else if (r_state == c_ST_EXEC) begin
            r_cnt      <= r_cnt - 5'd1;
        end
    end

    // Remember the destination of the most recent legal completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_rd  <= '0;
            r_last_vld <= 1'b0;
        end else if (w_done && !r_illegal) begin
            r_last_rd  <= r_rd;
            r_last_vld <= 1'b1;
        end
    end

    // Outputs
    assign in_ready    = w_ready;
    assign alu_oper    = r_alu_oper;
    assign alu_fwd1    = r_fwd1;
    assign alu_fwd2    = r_fwd2;
    assign out_valid   = w_done;
    assign out_rd      = r_rd;
    assign out_illegal = r_illegal;
    assign alu_cap     = w_done && !r_illegal;
    assign busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4, cycles from issue to result for multiply (oper 7'h03); legal range 2..15.
REQ-002 Parameter DIV_LAT, default 16, cycles from issue to result for divide (oper 7'h04); legal range 2..31.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  instruction offered.
REQ-007 in_ready  out  1  controller accepts the instruction; issue = in_valid & in_ready at a rising edge.
REQ-008 in_oper  in  7  operation code: 1=add, 2=sub, 3=mul, 4=div; other codes are illegal.
REQ-009 in_rd, in_rs1, in_rs2  in  5 each  destination and source register indices; index 0 never forwards.
REQ-010 alu_oper  out  7  operation code driven to the ALU.
REQ-011 alu_fwd1, alu_fwd2  out  1 each  ALU source select: forwarded result (1) or register file (0).
REQ-012 alu_cap  out  1  ALU result-capture strobe.
REQ-013 out_valid  out  1  one-cycle pulse: result is ready on the ALU output.
REQ-014 out_rd  out  5  destination index of the completing instruction, valid with out_valid.
REQ-015 out_illegal  out  1  the completing instruction had an illegal opcode, valid with out_valid.
REQ-016 busy  out  1  state is not IDLE.

Function
REQ-017 States SHALL be IDLE and EXEC, held with a 5-bit down-counter cnt.
- IDLE, issue: go to EXEC, cnt = LAT-1.
- EXEC, cnt>0: cnt decrements each cycle.
- EXEC, cnt==0: out_valid; then to EXEC on issue in the same cycle, else to IDLE.
REQ-018 LAT SHALL be 1 for add/sub/illegal, MUL_LAT for mul and DIV_LAT for div.
REQ-019 alu_oper, alu_fwd1 and alu_fwd2 SHALL be registered at issue and held constant for the whole EXEC occupancy; in IDLE alu_oper = 0.
REQ-020 An illegal opcode SHALL drive alu_oper = 0, complete after 1 cycle, and assert out_illegal with out_valid.
REQ-021 in_ready SHALL be combinational: 1 in IDLE, 1 in EXEC with cnt==0, and 0 otherwise; this permits back-to-back issue with no bubble.
REQ-022 out_valid SHALL be asserted exactly LAT cycles after the issue edge, for one cycle.
REQ-023 The controller SHALL keep a last_rd register and a last_vld flag for the most recently completed legal instruction; both update on out_valid.
REQ-024 alu_fwd1 SHALL be set at issue when the issued in_rs1 matches the rd of the forwarding source and that rd is non-zero. The source is the instruction completing in the same cycle, if one completes; otherwise it is last_rd with last_vld set. alu_fwd2 SHALL use the same rule with in_rs2.
REQ-025 alu_cap SHALL equal out_valid & ~out_illegal.
REQ-026 If in_valid is high while in_ready is low, the controller SHALL not accept the instruction, and no state shall change from it.

Reset
REQ-027 On rst, the state SHALL go to IDLE, and cnt, alu_oper, alu_fwd1, alu_fwd2, alu_cap, out_valid, out_rd, out_illegal, last_rd and last_vld SHALL all be 0.
REQ-028 rst during EXEC SHALL abort the operation: no out_valid is produced for it, and in_ready = 1 in the cycle after reset is released.
REQ-029 rst SHALL take priority over a simultaneous issue.

Structure
REQ-030 A shared package alu_pkg SHALL hold the opcode constants OP_ADD/SUB/MUL/DIV, the state enum and the default latencies.
REQ-031 An optional sub-module alu_lat_lut SHALL map an opcode to LAT and an illegal flag; this mapping is combinational.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- add issued at T0 with rd=3 -> out_valid=1 at T1 with out_rd=3, alu_cap=1, alu_oper=1.
- mul issued at T0 (MUL_LAT=4), add offered at T1..T3 -> in_ready=0 through T3; out_valid at T4; the add is accepted at T4.
- add rd=5, then sub rs1=5 issued back-to-back -> sub has alu_fwd1=1, alu_fwd2=0; an instruction with rd=0 causes no forwarding.
- oper=7'h07 issued -> alu_oper=0, out_valid with out_illegal=1 after 1 cycle, alu_cap=0, last_rd unchanged.
- div issued, rst asserted at cycle 5 -> no out_valid; all outputs 0; busy=0 the cycle after reset is released.
- a stream of 8 adds with in_valid held at 1 -> 8 consecutive out_valid pulses with no bubble.
